clk_period_meter: RTL and testbench

- Measures the period and high time of a slow, clock-like input signal in units of `clk_in` cycles.
- Flags lock when the measured period matches an expected value; flags timeout when the input stops toggling.
- Receive-side counterpart to the team's frequency divider: a divided clock (e.g. `clk_in`/250) is fed back in on `sig_in` and checked for correct rate and duty cycle.
- Used for self-check of divided clocks and for recovering the bit rate of the encoder/decoder link.

---
 rtl/clk_period_meter.sv | 179 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of sig_in in clk_in cycles, with lock/timeout flags.
// Build option GLITCH_FILTER_EN inserts a FILTER_LEN-sample stability filter after the synchroniser.
module clk_period_meter #(
  parameter int EXPECTED_PERIOD = 250,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_COUNT      = 4,
  parameter int MAX_PERIOD      = 1023,
`ifdef GLITCH_FILTER_EN
  parameter int FILTER_LEN      = 3,
`endif
  localparam int CW = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    MEAS   = 1'b1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PERIOD);
  localparam logic [CW-1:0] EXP_C  = CW'(EXPECTED_PERIOD);
  localparam logic [CW-1:0] TOL_C  = CW'(TOLERANCE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);

  logic          sync1_q, sync2_q, prev_q, level_s, rise_s, fall_s;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
  logic [CW-1:0] diff_s;
  logic          fall_seen_q, fall_seen_d, in_tol_s;
  logic [MW-1:0] match_q, match_d, match_inc_s;
  logic          valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;

  // Two-flop synchroniser for the asynchronous input
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // Level follows the synchronised input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end
  assign level_s = filt_q;
`else
  assign level_s = sync2_q;
`endif

  // Edge-detect flop on the (optionally filtered) level
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level_s;
  end

  assign rise_s      = level_s & ~prev_q;
  assign fall_s      = ~level_s & prev_q;
  assign diff_s      = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
  assign in_tol_s    = (diff_s <= TOL_C);
  assign match_inc_s = (match_q == LOCK_C) ? match_q : (match_q + MW'(1));

  // Measurement state machine, lock tracking and timeout detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    fall_seen_d = fall_seen_q;
    match_d     = match_q;
    period_d    = period_q;
    high_d      = high_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          cnt_d       = ONE_C;
          fall_seen_d = 1'b0;
          state_d     = MEAS;
        end else begin
          cnt_d = '0;
        end
      end
      MEAS: begin
        if (rise_s) begin
          period_d    = cnt_q;
          high_d      = fall_seen_q ? hi_q : cnt_q;
          valid_d     = 1'b1;
          cnt_d       = ONE_C;
          fall_seen_d = 1'b0;
          if (in_tol_s) begin
            match_d  = match_inc_s;
            locked_d = (match_inc_s == LOCK_C);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == MAX_C) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          match_d   = '0;
          locked_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (fall_s) begin
            hi_d        = cnt_q;
            fall_seen_d = 1'b1;
          end else begin
            hi_d = hi_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      fall_seen_q <= 1'b0;
      match_q     <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      fall_seen_q <= fall_seen_d;
      match_q     <= match_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: event-timestamp reference model checked every cycle, plus literal pins.
module tb_clk_period_meter;
  localparam int EXP   = 250;
  localparam int TOL   = 2;
  localparam int LOCKN = 4;
  localparam int MAXP  = 1023;

  logic       clk_in = 1'b0;
  logic       rst_n, sig_in;
  logic [9:0] period, high_time;
  logic       period_valid, locked, timeout;

  clk_period_meter #(
    .EXPECTED_PERIOD(EXP), .TOLERANCE(TOL), .LOCK_COUNT(LOCKN), .MAX_PERIOD(MAXP)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .period(period),
    .high_time(high_time), .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sampled-input history (fixed 3-edge latency) and event timestamps
  int       now = 0;
  logic [3:0] hist = 4'b0000;
  bit       meas = 1'b0, fall_seen = 1'b0;
  int       t_rise = 0, t_fall = 0, streak = 0;
  int       e_period = 0, e_high = 0;
  bit       e_valid = 1'b0, e_locked = 1'b0, e_timeout = 1'b0;

  // Observations of the DUT used by the literal pins
  int pv_cnt = 0, lock_at_pv = -1, last_pv_cyc = 0, to_cyc = 0, to_count = 0;
  int first_per = 0, first_high = 0, last_per = 0, last_high = 0;
  bit saw_drop260 = 1'b0, locked_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, now);
    end
  endtask

  task automatic model_step();
    bit rise, fall;
    int p;
    now++;
    e_valid   = 1'b0;
    e_timeout = 1'b0;
    if (!rst_n) begin
      hist = 4'b0000; meas = 1'b0; streak = 0;
      e_period = 0; e_high = 0; e_locked = 1'b0;
      return;
    end
    hist = {hist[2:0], sig_in};
    rise = hist[2] && !hist[3];
    fall = !hist[2] && hist[3];
    if (!meas) begin
      if (rise) begin meas = 1'b1; t_rise = now; fall_seen = 1'b0; end
    end else if (rise) begin
      p        = now - t_rise;
      e_period = p;
      e_high   = fall_seen ? (t_fall - t_rise) : p;
      e_valid  = 1'b1;
      streak   = (p >= EXP - TOL && p <= EXP + TOL) ? streak + 1 : 0;
      e_locked = (streak >= LOCKN);
      t_rise   = now;
      fall_seen = 1'b0;
    end else if (now - t_rise == MAXP) begin
      e_timeout = 1'b1; meas = 1'b0; streak = 0; e_locked = 1'b0;
    end else if (fall) begin
      fall_seen = 1'b1; t_fall = now;
    end
  endtask

  task automatic step(input logic s);
    sig_in = s;
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    chk("period", int'(period), e_period);
    chk("high_time", int'(high_time), e_high);
    chk("period_valid", int'(period_valid), int'(e_valid));
    chk("locked", int'(locked), int'(e_locked));
    chk("timeout", int'(timeout), int'(e_timeout));
    if (period_valid) begin
      pv_cnt++;
      last_pv_cyc = now; last_per = int'(period); last_high = int'(high_time);
      if (pv_cnt == 1) begin first_per = int'(period); first_high = int'(high_time); end
      if (period == 10'd260 && !locked) saw_drop260 = 1'b1;
    end
    if (locked && !locked_prev) lock_at_pv = pv_cnt;
    locked_prev = locked;
    if (timeout) begin to_cyc = now; to_count++; end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    @(negedge clk_in);
    hold(1'b0, 3);
    chk("reset_period", int'(period), 0);
    chk("reset_high", int'(high_time), 0);
    chk("reset_valid", int'(period_valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    hold(1'b0, 10);

    // Divider output 250/125: lock on the 4th valid pulse (5th rise)
    pv_cnt = 0;
    wave(250, 125, 5);
    chk("lock_pv_count", pv_cnt, 4);
    chk("first_period", first_per, 250);
    chk("first_high", first_high, 125);
    chk("lock_at_pv", lock_at_pv, 4);
    chk("locked_after_5_rises", int'(locked), 1);

    // One out-of-tolerance period then 248s
    wave(260, 130, 1);
    wave(248, 124, 5);
    chk("drop_on_260", int'(saw_drop260), 1);
    chk("relock_248", int'(locked), 1);
    chk("last_period_248", last_per, 248);

    // Input stops: timeout 1023 cycles after the last counted rise
    hold(1'b0, 1100);
    chk("timeout_delay", to_cyc - last_pv_cyc, MAXP);
    chk("locked_after_timeout", int'(locked), 0);
    pv_cnt = 0;
    wave(250, 125, 1);
    chk("rearm_no_valid", pv_cnt, 0);

    // Duty sweep at period 100
    wave(100, 1, 2);
    chk("duty_1", last_high, 1);
    wave(100, 50, 2);
    chk("duty_50", last_high, 50);
    wave(100, 99, 2);
    chk("duty_99", last_high, 99);
    chk("duty_period", last_per, 100);

    // Reset mid-period
    hold(1'b1, 60);
    rst_n = 1'b0;
    #1;
    chk("midrst_period", int'(period), 0);
    chk("midrst_high", int'(high_time), 0);
    chk("midrst_valid", int'(period_valid), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_timeout", int'(timeout), 0);
    hold(1'b1, 5);
    rst_n = 1'b1;
    pv_cnt = 0;
    hold(1'b0, 50);
    wave(250, 125, 3);
    chk("post_rst_valids", pv_cnt, 2);
    chk("post_rst_period", first_per, 250);

    // 2-cycle glitch inside the low phase (no filter: short period reported)
    pv_cnt = 0;
    hold(1'b1, 125); hold(1'b0, 60); hold(1'b1, 2); hold(1'b0, 63);
    hold(1'b1, 125); hold(1'b0, 125);
    chk("glitch_valids", pv_cnt, 3);
    chk("glitch_last_period", last_per, 65);
    chk("glitch_last_high", last_high, 2);

    // Randomised periods and duty, with one long gap
    for (int k = 0; k < 40; k++) begin
      int p, h;
      if ($urandom_range(0, 1) == 1) p = int'($urandom_range(EXP - 4, EXP + 4));
      else                           p = int'($urandom_range(4, 400));
      h = int'($urandom_range(1, p - 1));
      wave(p, h, 1);
      if (k == 20) hold(1'b0, 1100);
    end

    // Rise coinciding with the counter ceiling wins over timeout
    wave(MAXP, 500, 1);
    begin
      int to_before;
      to_before = to_count;
      wave(MAXP, 500, 2);
      chk("period_at_max", last_per, MAXP);
      chk("no_timeout_at_max", to_count, to_before);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
